vend_fsm_param: RTL and testbench

VEND_FSM_PARAM -- requirements
Module: vend_fsm_param

---
 rtl/vend_fsm_param.sv | 185 ++++++++++++++++++
 tb/tb_vend_fsm_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_param.sv
// Parameterised vending-machine controller.
//
// Accepts coins into a credit register, dispenses one of N_PROD products on a
// one-hot selection, and presents change or a cancel refund until the
// customer acknowledges it. Every output is registered, so each response
// shows up the cycle after the input that caused it.
//
// Parameters:
//   N_PROD     number of products (1..8)
//   W          width of credit, coin, price and change values
//   PRICES     packed prices, product i at PRICES[i*W +: W], each >= 1
//   MAX_CREDIT highest credit accepted (<= 2^W-1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   coin_valid   coin present this cycle
//   coin_value   value of the coin
//   sel          one-hot product select pulse
//   cancel       refund request pulse
//   change_ack   change taken
//   credit       current accumulated credit
//   dispense     one-cycle dispense pulse
//   disp_id      index of the product being dispensed
//   change_valid change is being presented
//   change       change amount (0 when change_valid is low)
//   coin_reject  one-cycle pulse, coin returned
//   insufficient one-cycle pulse, selection refused for lack of credit
//   busy         high while dispensing or presenting change
module vend_fsm_param #(
  parameter int unsigned         N_PROD     = 2,
  parameter int unsigned         W          = 4,
  parameter logic [N_PROD*W-1:0] PRICES     = {4'd3, 4'd2},
  parameter int unsigned         MAX_CREDIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_valid,
  input  logic [W-1:0]      coin_value,
  input  logic [N_PROD-1:0] sel,
  input  logic              cancel,
  input  logic              change_ack,
  output logic [W-1:0]      credit,
  output logic              dispense,
  output logic [2:0]        disp_id,
  output logic              change_valid,
  output logic [W-1:0]      change,
  output logic              coin_reject,
  output logic              insufficient,
  output logic              busy
);

  localparam logic [W:0] LpMax = (W + 1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDispense,
    StChange
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_credit;
  logic [W-1:0]   r_chg;       // change owed after a dispense, shown in StChange
  logic [W-1:0]   r_change;
  logic [2:0]     r_disp_id;
  logic           r_dispense;
  logic           r_change_valid;
  logic           r_coin_reject;
  logic           r_insufficient;
  logic           r_busy;

  logic [W:0]     w_sum;        // one bit wider so a 2^W wrap cannot hide an overflow
  logic           w_sel_onehot;
  logic [2:0]     w_sel_idx;
  logic [W-1:0]   w_price;
  logic           w_coin_fits;
  logic           w_can_buy;

  always_comb begin
    w_sum        = {1'b0, r_credit} + {1'b0, coin_value};
    w_sel_onehot = $onehot(sel);
    w_sel_idx    = '0;
    w_price      = '0;
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (sel[i]) begin
        w_sel_idx = 3'(i);
        w_price   = PRICES[i*W +: W];
      end
    end
    w_coin_fits = (coin_value != '0) && ({1'b0, coin_value} <= LpMax);
    w_can_buy   = w_sel_onehot && (r_credit >= w_price);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_credit       <= '0;
      r_chg          <= '0;
      r_change       <= '0;
      r_disp_id      <= '0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_dispense     <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
      case (r_state)
        StIdle: begin
          if (coin_valid) begin
            if (w_coin_fits) begin
              r_credit <= coin_value;
              r_state  <= StCollect;
            end else if (coin_value != '0) begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        StCollect: begin
          if (cancel) begin
            r_change       <= r_credit;
            r_change_valid <= 1'b1;
            r_credit       <= '0;
            r_busy         <= 1'b1;
            r_state        <= StChange;
            r_coin_reject  <= coin_valid;
          end else if (w_can_buy) begin
            r_chg         <= r_credit - w_price;
            r_credit      <= '0;
            r_disp_id     <= w_sel_idx;
            r_dispense    <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= StDispense;
            r_coin_reject <= coin_valid;
          end else begin
            // A refused or malformed selection does not consume the cycle's coin.
            r_insufficient <= w_sel_onehot;
            if (coin_valid) begin
              if (w_sum <= LpMax) begin
                r_credit <= w_sum[W-1:0];
              end else begin
                r_coin_reject <= 1'b1;
              end
            end
          end
        end
        StDispense: begin
          r_coin_reject <= coin_valid;
          if (r_chg != '0) begin
            r_change       <= r_chg;
            r_change_valid <= 1'b1;
            r_state        <= StChange;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StChange: begin
          r_coin_reject <= coin_valid;
          if (change_ack) begin
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_chg          <= '0;
            r_busy         <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign credit       = r_credit;
  assign dispense     = r_dispense;
  assign disp_id      = r_disp_id;
  assign change_valid = r_change_valid;
  assign change       = r_change;
  assign coin_reject  = r_coin_reject;
  assign insufficient = r_insufficient;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param: default-parameter instance plus a
// four-product instance, sharing clock and reset.
module tb_vend_fsm_param;

  logic       clk;
  logic       reset;

  // Default-parameter instance
  logic       coin_valid;
  logic [3:0] coin_value;
  logic [1:0] sel;
  logic       cancel;
  logic       change_ack;
  logic [3:0] credit;
  logic       dispense;
  logic [2:0] disp_id;
  logic       change_valid;
  logic [3:0] change;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  // Four-product instance
  logic       p_coin_valid;
  logic [5:0] p_coin_value;
  logic [3:0] p_sel;
  logic       p_cancel;
  logic       p_change_ack;
  logic [5:0] p_credit;
  logic       p_dispense;
  logic [2:0] p_disp_id;
  logic       p_change_valid;
  logic [5:0] p_change;
  logic       p_coin_reject;
  logic       p_insufficient;
  logic       p_busy;

  int n_assert = 0;
  int n_fail   = 0;

  vend_fsm_param u_dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel          (sel),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .credit       (credit),
    .dispense     (dispense),
    .disp_id      (disp_id),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .busy         (busy)
  );

  vend_fsm_param #(
    .N_PROD     (4),
    .W          (6),
    .PRICES     ({6'd20, 6'd15, 6'd10, 6'd5}),
    .MAX_CREDIT (40)
  ) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (p_coin_valid),
    .coin_value   (p_coin_value),
    .sel          (p_sel),
    .cancel       (p_cancel),
    .change_ack   (p_change_ack),
    .credit       (p_credit),
    .dispense     (p_dispense),
    .disp_id      (p_disp_id),
    .change_valid (p_change_valid),
    .change       (p_change),
    .coin_reject  (p_coin_reject),
    .insufficient (p_insufficient),
    .busy         (p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock edge, then return to idle inputs 1 ns after the edge.
  task automatic drive(input logic cv, input logic [3:0] cval, input logic [1:0] s,
                       input logic cn, input logic ak);
    coin_valid = cv;
    coin_value = cval;
    sel        = s;
    cancel     = cn;
    change_ack = ak;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_value = '0;
    sel        = '0;
    cancel     = 1'b0;
    change_ack = 1'b0;
  endtask

  task automatic drive4(input logic cv, input logic [5:0] cval, input logic [3:0] s,
                        input logic ak);
    p_coin_valid = cv;
    p_coin_value = cval;
    p_sel        = s;
    p_change_ack = ak;
    @(posedge clk);
    #1;
    p_coin_valid = 1'b0;
    p_coin_value = '0;
    p_sel        = '0;
    p_change_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_credit"}, 32'(credit), 0);
    chk({tag, "_dispense"}, 32'(dispense), 0);
    chk({tag, "_disp_id"}, 32'(disp_id), 0);
    chk({tag, "_chg_valid"}, 32'(change_valid), 0);
    chk({tag, "_change"}, 32'(change), 0);
    chk({tag, "_coin_rej"}, 32'(coin_reject), 0);
    chk({tag, "_insuff"}, 32'(insufficient), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    reset        = 1'b1;
    coin_valid   = 1'b0;
    coin_value   = '0;
    sel          = '0;
    cancel       = 1'b0;
    change_ack   = 1'b0;
    p_coin_valid = 1'b0;
    p_coin_value = '0;
    p_sel        = '0;
    p_cancel     = 1'b0;
    p_change_ack = 1'b0;

    @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Coins 2 + 2, buy product 1 (price 3), change 1
    drive(1, 4'd2, 2'b00, 0, 0);
    chk("d_credit2", 32'(credit), 2);
    drive(1, 4'd2, 2'b00, 0, 0);
    chk("d_credit4", 32'(credit), 4);
    drive(0, 4'd0, 2'b10, 0, 0);
    chk("d_dispense", 32'(dispense), 1);
    chk("d_disp_id", 32'(disp_id), 1);
    chk("d_busy", 32'(busy), 1);
    chk("d_credit0", 32'(credit), 0);
    chk("d_cv_in_disp", 32'(change_valid), 0);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("d_disp_pulse", 32'(dispense), 0);
    chk("d_chg_valid", 32'(change_valid), 1);
    chk("d_change1", 32'(change), 1);
    chk("d_disp_id_hold", 32'(disp_id), 1);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("d_chg_hold", 32'(change), 1);
    chk("d_cv_hold", 32'(change_valid), 1);
    drive(0, 4'd0, 2'b00, 0, 1);
    chk("d_ack_cv", 32'(change_valid), 0);
    chk("d_ack_change", 32'(change), 0);
    chk("d_ack_busy", 32'(busy), 0);

    // Exact price: coin 2, product 0 (price 2)
    drive(1, 4'd2, 2'b00, 0, 0);
    chk("e_credit", 32'(credit), 2);
    drive(0, 4'd0, 2'b01, 0, 0);
    chk("e_dispense", 32'(dispense), 1);
    chk("e_disp_id", 32'(disp_id), 0);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("e_no_cv", 32'(change_valid), 0);
    chk("e_idle_busy", 32'(busy), 0);
    chk("e_disp_off", 32'(dispense), 0);

    // Zero coin in idle is ignored
    drive(1, 4'd0, 2'b00, 0, 0);
    chk("z_credit", 32'(credit), 0);
    chk("z_reject", 32'(coin_reject), 0);

    // Overflow: 9 + 5 = 14, +3 rejected, then cancel refunds 14
    drive(1, 4'd9, 2'b00, 0, 0);
    chk("o_credit9", 32'(credit), 9);
    drive(1, 4'd5, 2'b00, 0, 0);
    chk("o_credit14", 32'(credit), 14);
    drive(1, 4'd3, 2'b00, 0, 0);
    chk("o_credit_hold", 32'(credit), 14);
    chk("o_reject", 32'(coin_reject), 1);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("o_reject_pulse", 32'(coin_reject), 0);
    drive(0, 4'd0, 2'b00, 1, 0);
    chk("o_cancel_cv", 32'(change_valid), 1);
    chk("o_cancel_chg", 32'(change), 14);
    chk("o_cancel_credit", 32'(credit), 0);
    drive(1, 4'd1, 2'b00, 0, 0);
    chk("o_chg_coin_rej", 32'(coin_reject), 1);
    chk("o_chg_held", 32'(change), 14);
    drive(0, 4'd0, 2'b00, 0, 1);
    chk("o_ack_cv", 32'(change_valid), 0);
    chk("o_ack_chg", 32'(change), 0);

    // Insufficient credit, then sel beats a same-cycle coin
    drive(1, 4'd2, 2'b00, 0, 0);
    chk("i_credit", 32'(credit), 2);
    drive(0, 4'd0, 2'b10, 0, 0);
    chk("i_insuff", 32'(insufficient), 1);
    chk("i_credit_hold", 32'(credit), 2);
    chk("i_no_disp", 32'(dispense), 0);
    drive(1, 4'd3, 2'b01, 0, 0);
    chk("i_coin_rej", 32'(coin_reject), 1);
    chk("i_dispense", 32'(dispense), 1);
    chk("i_disp_id", 32'(disp_id), 0);
    chk("i_insuff_off", 32'(insufficient), 0);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("i_no_change", 32'(change_valid), 0);
    chk("i_idle", 32'(busy), 0);

    // Reset mid-CHANGE: coin 5, product 0 leaves change 3
    drive(1, 4'd5, 2'b00, 0, 0);
    chk("r_credit", 32'(credit), 5);
    drive(0, 4'd0, 2'b01, 0, 0);
    chk("r_dispense", 32'(dispense), 1);
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("r_cv", 32'(change_valid), 1);
    chk("r_change3", 32'(change), 3);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("r_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 4'd0, 2'b00, 0, 0);
    chk("r_post_cv", 32'(change_valid), 0);
    chk("r_post_chg", 32'(change), 0);
    drive(1, 4'd1, 2'b00, 0, 0);
    chk("r_post_credit", 32'(credit), 1);

    // Multi-hot selection ignored without a pulse
    drive(0, 4'd0, 2'b11, 0, 0);
    chk("m_insuff", 32'(insufficient), 0);
    chk("m_disp", 32'(dispense), 0);
    chk("m_credit", 32'(credit), 1);
    drive(0, 4'd0, 2'b00, 1, 0);
    chk("m_cancel_chg", 32'(change), 1);
    drive(0, 4'd0, 2'b00, 0, 1);
    chk("m_ack", 32'(change_valid), 0);

    // Cancel in idle is ignored
    drive(0, 4'd0, 2'b00, 1, 0);
    chk("c_idle_cv", 32'(change_valid), 0);
    chk("c_idle_busy", 32'(busy), 0);

    // Four products: 25 + 10 = 35, product 3 (price 20), change 15
    drive4(1, 6'd25, 4'b0000, 0);
    chk("p_credit25", 32'(p_credit), 25);
    drive4(1, 6'd10, 4'b0000, 0);
    chk("p_credit35", 32'(p_credit), 35);
    drive4(0, 6'd0, 4'b1000, 0);
    chk("p_dispense", 32'(p_dispense), 1);
    chk("p_disp_id", 32'(p_disp_id), 3);
    drive4(0, 6'd0, 4'b0000, 0);
    chk("p_cv", 32'(p_change_valid), 1);
    chk("p_change15", 32'(p_change), 15);
    drive4(0, 6'd0, 4'b0000, 1);
    chk("p_ack_cv", 32'(p_change_valid), 0);
    chk("p_ack_busy", 32'(p_busy), 0);
    chk("p_no_reject", 32'(p_coin_reject), 0);
    chk("p_no_insuff", 32'(p_insufficient), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
